// File: rtl/ks_voice_scheduler.sv
// -----------------------------------------------------------------------------
// ks_voice_scheduler
//
// Voice allocator and sequencer for a bank of Karplus-Strong string engines.
// Note requests arrive over a valid/ready handshake. Each request goes to the
// lowest free engine. When no engine is free, the scheduler steals the ringing
// engine that is closest to the end of its life. For the chosen engine it
// drives the stringlen configuration and a pluck pulse timed in sample ticks,
// and it tracks how long the voice rings out.
//
// Ports:
//   Clk           system clock
//   Reset         synchronous, active-low reset
//   data_over     sample-rate strobe; each rising edge is one sample tick
//   note_valid    a note request is present
//   note_ready    a note can be accepted this cycle
//   note_len      requested string (delay-line) length
//   voice_pluck   per-engine pluck level
//   voice_len     per-engine stringlen; voice i is bits [i*LEN_W +: LEN_W]
//   voice_active  per-engine busy flag (GAP, PLUCK or RING)
//   alloc_idx     voice taken by the last accepted note
//   alloc_stolen  one-cycle pulse: the last accept stole a ringing voice
// -----------------------------------------------------------------------------
module ks_voice_scheduler #(
  parameter  int NUM_VOICES    = 4,
  parameter  int LEN_W         = 10,
  parameter  int PLUCK_SAMPLES = 8,
  parameter  int VOICE_LIFE    = 48000,
  localparam int IDX_W         = $clog2(NUM_VOICES)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        data_over,
  input  logic                        note_valid,
  output logic                        note_ready,
  input  logic [LEN_W-1:0]            note_len,
  output logic [NUM_VOICES-1:0]       voice_pluck,
  output logic [NUM_VOICES*LEN_W-1:0] voice_len,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [IDX_W-1:0]            alloc_idx,
  output logic                        alloc_stolen
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LIFE_INIT  = CNT_W'(VOICE_LIFE);
  localparam logic [CNT_W-1:0] PLUCK_LAST = CNT_W'(PLUCK_SAMPLES - 1);
  localparam logic [LEN_W-1:0] MIN_LEN    = LEN_W'(2);

  typedef enum logic [1:0] {
    V_IDLE,
    V_GAP,
    V_PLUCK,
    V_RING
  } voice_state_t;

  voice_state_t     state_q [NUM_VOICES];
  voice_state_t     state_d [NUM_VOICES];
  logic [CNT_W-1:0] cnt_q   [NUM_VOICES];
  logic [CNT_W-1:0] cnt_d   [NUM_VOICES];
  logic [LEN_W-1:0] len_q   [NUM_VOICES];

  logic             data_over_q;
  logic             tick;

  logic             found_idle;
  logic             found_ring;
  logic [IDX_W-1:0] idle_idx;
  logic [IDX_W-1:0] ring_idx;
  logic [CNT_W-1:0] ring_min;
  logic             target_valid;
  logic             target_steal;
  logic [IDX_W-1:0] target_idx;
  logic             accept;
  logic [LEN_W-1:0] clamped_len;

  // One tick per rising edge of the codec strobe.
  assign tick = data_over & ~data_over_q;

  // Target selection: lowest idle voice first, otherwise the ringing voice
  // with the least life left. The strict '<' keeps the lowest index on ties.
  always_comb begin
    found_idle = 1'b0;
    found_ring = 1'b0;
    idle_idx   = '0;
    ring_idx   = '0;
    ring_min   = '1;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (state_q[i] == V_IDLE && !found_idle) begin
        found_idle = 1'b1;
        idle_idx   = IDX_W'(i);
      end
      if (state_q[i] == V_RING && (!found_ring || cnt_q[i] < ring_min)) begin
        found_ring = 1'b1;
        ring_idx   = IDX_W'(i);
        ring_min   = cnt_q[i];
      end
    end
    target_valid = found_idle | found_ring;
    target_steal = ~found_idle & found_ring;
    target_idx   = found_idle ? idle_idx : ring_idx;
  end

  // Held low while Reset is asserted even though every voice is already idle.
  assign note_ready  = target_valid & Reset;
  assign accept      = note_valid & note_ready;
  assign clamped_len = (note_len < MIN_LEN) ? MIN_LEN : note_len;

  // Per-voice next state. The accept override comes last, so a tick in the
  // accept cycle is never counted by the voice being (re)allocated.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        V_GAP: begin
          // Two idle-level cycles so a stolen engine sees a fresh pluck edge.
          if (cnt_q[i] == CNT_W'(1)) begin
            state_d[i] = V_PLUCK;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        V_PLUCK: begin
          if (PLUCK_SAMPLES == 0) begin
            state_d[i] = V_RING;
            cnt_d[i]   = LIFE_INIT;
          end else if (tick) begin
            if (cnt_q[i] == PLUCK_LAST) begin
              state_d[i] = V_RING;
              cnt_d[i]   = LIFE_INIT;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        V_RING: begin
          if (tick) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = V_IDLE;
            end
          end
        end
        default: ;
      endcase
      if (accept && target_idx == IDX_W'(i)) begin
        state_d[i] = target_steal ? V_GAP : V_PLUCK;
        cnt_d[i]   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all decision
  // logic lives in the always_comb blocks above.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      data_over_q  <= 1'b0;
      alloc_idx    <= '0;
      alloc_stolen <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= V_IDLE;
        cnt_q[i]   <= '0;
        // NOTE: the length registers are reset too, because the engines must
        // see a zero stringlen after reset rather than a stale one.
        len_q[i]   <= '0;
      end
    end else begin
      data_over_q  <= data_over;
      alloc_stolen <= accept & target_steal;
      if (accept) begin
        alloc_idx <= target_idx;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        if (accept && target_idx == IDX_W'(i)) begin
          len_q[i] <= clamped_len;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_pluck[g]                  = (state_q[g] == V_PLUCK);
    assign voice_active[g]                 = (state_q[g] != V_IDLE);
    assign voice_len[g*LEN_W +: LEN_W]     = len_q[g];
  end

endmodule

// File: tb/tb_ks_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ks_voice_scheduler
//
// Directed bench for ks_voice_scheduler with two voices, a two-tick pluck and
// a five-tick ring. data_over toggles every 10 clocks once reset is released.
// The bench tracks which clock edge consumes each sample tick, so pluck and
// ring lengths can be measured in ticks.
// -----------------------------------------------------------------------------
module tb_ks_voice_scheduler;

  localparam int NV    = 2;
  localparam int LW    = 10;
  localparam int PS    = 2;
  localparam int LIFE  = 5;
  localparam int BOUND = 1000;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          data_over = 1'b0;
  logic          note_valid = 1'b0;
  logic          note_ready;
  logic [LW-1:0] note_len = '0;
  logic [NV-1:0] voice_pluck;
  logic [NV*LW-1:0] voice_len;
  logic [NV-1:0] voice_active;
  logic          alloc_idx;
  logic          alloc_stolen;

  int n_cmp  = 0;
  int n_fail = 0;

  // Tick bookkeeping: do_en starts the strobe, rise_pend marks a rising edge
  // driven after the last clock edge (consumed at the next one).
  bit do_en     = 1'b0;
  bit rise_pend = 1'b0;
  bit last_tick = 1'b0;
  int cyc       = 0;
  int ticks     = 0;
  int t0;

  ks_voice_scheduler #(
    .NUM_VOICES   (NV),
    .LEN_W        (LW),
    .PLUCK_SAMPLES(PS),
    .VOICE_LIFE   (LIFE)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .data_over   (data_over),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_len    (note_len),
    .voice_pluck (voice_pluck),
    .voice_len   (voice_len),
    .voice_active(voice_active),
    .alloc_idx   (alloc_idx),
    .alloc_stolen(alloc_stolen)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    last_tick = rise_pend;
    if (rise_pend) ticks++;
    rise_pend = 1'b0;
    #1;
    if (do_en) begin
      cyc++;
      if (cyc % 10 == 0) begin
        data_over = ~data_over;
        rise_pend = data_over;
      end
    end
  endtask

  task automatic send(input logic [LW-1:0] len);
    note_valid = 1'b1;
    note_len   = len;
    step();
    note_valid = 1'b0;
  endtask

  // sel: 0 = voice_pluck, 1 = voice_active, other = note_ready
  task automatic wait_for(input string tag, input int sel, input logic [1:0] val);
    bit hit = 1'b0;
    for (int i = 0; i < BOUND && !hit; i++) begin
      step();
      case (sel)
        0:       hit = (voice_pluck == val);
        1:       hit = (voice_active == val);
        default: hit = (note_ready == val[0]);
      endcase
    end
    check({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  task automatic sync_tick(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < BOUND && !hit; i++) begin
      step();
      hit = last_tick;
    end
    check({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_pluck",  32'(voice_pluck),  32'd0);
    check("rst_len",    32'(voice_len),    32'd0);
    check("rst_active", 32'(voice_active), 32'd0);
    check("rst_idx",    32'(alloc_idx),    32'd0);
    check("rst_stolen", 32'(alloc_stolen), 32'd0);
    check("rst_ready",  32'(note_ready),   32'd0);
    Reset = 1'b1;
    do_en = 1'b1;
    #1;
    check("ready_after_rst", 32'(note_ready), 32'd1);

    // 1: single note, pluck 2 ticks, ring 5 ticks
    send(10'd147);
    t0 = ticks;
    check("t1_pluck",  32'(voice_pluck),      32'b01);
    check("t1_len0",   32'(voice_len[9:0]),   32'd147);
    check("t1_active", 32'(voice_active),     32'b01);
    check("t1_idx",    32'(alloc_idx),        32'd0);
    check("t1_stolen", 32'(alloc_stolen),     32'd0);
    wait_for("t1_pluck_end", 0, 2'b00);
    check("t1_pluck_ticks", 32'(ticks - t0), 32'd2);
    check("t1_pluck_edge",  32'(last_tick),  32'd1);
    check("t1_ring_active", 32'(voice_active), 32'b01);
    t0 = ticks;
    wait_for("t1_idle", 1, 2'b00);
    check("t1_ring_ticks", 32'(ticks - t0),    32'd5);
    check("t1_ring_edge",  32'(last_tick),     32'd1);
    check("t1_len_hold",   32'(voice_len[9:0]), 32'd147);

    // 2 + 4: back-to-back notes, third note waits, then tie steal picks voice 0
    sync_tick("t2_sync");
    note_valid = 1'b1;
    note_len   = 10'd147;
    step();
    note_len   = 10'd110;
    step();
    note_valid = 1'b0;
    check("t2_len0",  32'(voice_len[9:0]),   32'd147);
    check("t2_len1",  32'(voice_len[19:10]), 32'd110);
    check("t2_idx",   32'(alloc_idx),        32'd1);
    check("t2_pluck", 32'(voice_pluck),      32'b11);
    check("t2_ready", 32'(note_ready),       32'd0);
    wait_for("t2_ready_rise", 2, 2'b01);
    check("t2_ring_pluck",  32'(voice_pluck),  32'b00);
    check("t2_ring_active", 32'(voice_active), 32'b11);
    send(10'd200);
    check("t4_tie_idx",    32'(alloc_idx),      32'd0);
    check("t4_tie_stolen", 32'(alloc_stolen),   32'd1);
    check("t4_tie_len0",   32'(voice_len[9:0]), 32'd200);

    // 3: voice 1 started one tick later, so voice 0 has less life left
    wait_for("t3_idle", 1, 2'b00);
    sync_tick("t3_sync_a");
    send(10'd50);
    sync_tick("t3_sync_b");
    send(10'd60);
    check("t3_idx_b", 32'(alloc_idx), 32'd1);
    wait_for("t3_both_ring", 0, 2'b00);
    check("t3_active", 32'(voice_active), 32'b11);
    send(10'd99);
    check("t3_idx",     32'(alloc_idx),         32'd0);
    check("t3_stolen",  32'(alloc_stolen),      32'd1);
    check("t3_len0",    32'(voice_len[9:0]),    32'd99);
    check("t3_len1",    32'(voice_len[19:10]),  32'd60);
    check("t3_gap_a",   32'(voice_pluck),       32'b00);
    step();
    check("t3_stolen_pulse", 32'(alloc_stolen), 32'd0);
    check("t3_gap_b",        32'(voice_pluck),  32'b00);
    step();
    check("t3_repluck",      32'(voice_pluck),  32'b01);

    // 3b: now voice 1 has less life left than the re-plucked voice 0
    wait_for("t3b_both_ring", 0, 2'b00);
    check("t3b_active", 32'(voice_active), 32'b11);
    send(10'd77);
    check("t3b_idx",    32'(alloc_idx),        32'd1);
    check("t3b_stolen", 32'(alloc_stolen),     32'd1);
    check("t3b_len1",   32'(voice_len[19:10]), 32'd77);
    check("t3b_len0",   32'(voice_len[9:0]),   32'd99);

    // 5: lengths 0 and 1 clamp to 2
    wait_for("t5_idle", 1, 2'b00);
    send(10'd0);
    send(10'd1);
    check("t5_len0", 32'(voice_len[9:0]),   32'd2);
    check("t5_len1", 32'(voice_len[19:10]), 32'd2);
    check("t5_idx",  32'(alloc_idx),        32'd1);

    // 6: one-cycle reset mid-pluck, then a note right after release
    check("t6_pre_pluck", 32'(voice_pluck), 32'b11);
    Reset = 1'b0;
    step();
    check("t6_pluck",  32'(voice_pluck),  32'd0);
    check("t6_len",    32'(voice_len),    32'd0);
    check("t6_active", 32'(voice_active), 32'd0);
    check("t6_stolen", 32'(alloc_stolen), 32'd0);
    check("t6_ready_in_rst", 32'(note_ready), 32'd0);
    Reset      = 1'b1;
    note_valid = 1'b1;
    note_len   = 10'd300;
    #1;
    check("t6_ready_after", 32'(note_ready), 32'd1);
    step();
    note_valid = 1'b0;
    check("t6_idx",   32'(alloc_idx),      32'd0);
    check("t6_len0",  32'(voice_len[9:0]), 32'd300);
    check("t6_pluck_new", 32'(voice_pluck), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
